// File: rtl/cpu_pkg.sv
// Shared encodings for the execution core: instruction modes and ALU ops,
// FSM state codes, flag bit positions and instruction field offsets.
package cpu_pkg;

  typedef enum logic [1:0] {
    MODE_ALU  = 2'b00,
    MODE_LDI  = 2'b01,
    MODE_ILL0 = 2'b10,
    MODE_ILL1 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam int FLAG_CO  = 0;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_DZ  = 2;
  localparam int FLAG_ILL = 3;

  // Instruction layout, MSB first: mode[2], op[2], rd, rs1, rs2.
  function automatic int instr_width(input int ridx);
    return 4 + 3 * ridx;
  endfunction

  function automatic int rs2_lsb(input int ridx);
    return 0 * ridx;
  endfunction

  function automatic int rs1_lsb(input int ridx);
    return ridx;
  endfunction

  function automatic int rd_lsb(input int ridx);
    return 2 * ridx;
  endfunction

  function automatic int op_lsb(input int ridx);
    return 3 * ridx;
  endfunction

  function automatic int mode_lsb(input int ridx);
    return 3 * ridx + 2;
  endfunction

endpackage

// File: rtl/seq_div.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// done_o is high in the cycle whose closing edge produces the final result.
module seq_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic             dz_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q;
  logic             dz_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // A zero divisor always "fits", giving an all-ones quotient and the
  // dividend as remainder without any special casing.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      dz_q  <= 1'b0;
    end else if (start_i) begin
      cnt_q <= CW'(WIDTH);
      quo_q <= dividend_i;
      rem_q <= '0;
      dsr_q <= divisor_i;
      dz_q  <= (divisor_i == '0);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign done_o      = (cnt_q == CW'(1));
  assign dz_o        = dz_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/cpu_exec_core.sv
// Multi-cycle execution core: register bank, single-cycle ALU for ADD/SUB/MUL/LDI
// and an iterative divider, sequenced by an IDLE/EXEC/DIV/WB state machine.
module cpu_exec_core
  import cpu_pkg::*;
#(
  parameter int NUM_REG   = 16,
  parameter int REG_WIDTH = 16,
  localparam int RIDX     = $clog2(NUM_REG),
  localparam int IW       = 4 + 3 * RIDX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [IW-1:0]        instr,
  output logic                 done,
  output logic                 busy,
  output logic [3:0]           flags,
  output logic [REG_WIDTH-1:0] rem_out,
  input  logic [RIDX-1:0]      dbg_sel,
  output logic [REG_WIDTH-1:0] dbg_data
);

  localparam int W        = REG_WIDTH;
  localparam int LW       = 2 * RIDX;
  localparam int RS2_LSB  = rs2_lsb(RIDX);
  localparam int RS1_LSB  = rs1_lsb(RIDX);
  localparam int RD_LSB   = rd_lsb(RIDX);
  localparam int OP_LSB   = op_lsb(RIDX);
  localparam int MODE_LSB = mode_lsb(RIDX);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] instr_q;
  logic [W-1:0]  opa_q, opb_q;
  logic [W-1:0]  result_q;
  logic [3:0]    eflags_q;
  logic [3:0]    flags_q;
  logic [W-1:0]  rem_q;
  logic          done_q;
  logic [W-1:0]  regs_q [NUM_REG];

  logic          accept;
  logic          in_is_div;
  logic [W-1:0]  rs1_val, rs2_val;
  logic [1:0]    q_mode, q_op;
  logic          q_is_div;
  logic [W-1:0]  alu_res;
  logic [3:0]    alu_flags;
  logic [W:0]    wide;
  logic [2*W-1:0] prod;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic [3:0]    wb_flags;
  logic          div_done, div_dz;
  logic [W-1:0]  div_quo, div_rem;

  assign instr_ready = (state_q == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign in_is_div   = (instr[MODE_LSB +: 2] == MODE_ALU) && (instr[OP_LSB +: 2] == OP_DIV);
  assign rs1_val     = regs_q[instr[RS1_LSB +: RIDX]];
  assign rs2_val     = regs_q[instr[RS2_LSB +: RIDX]];

  assign q_mode   = instr_q[MODE_LSB +: 2];
  assign q_op     = instr_q[OP_LSB +: 2];
  assign q_is_div = (q_mode == MODE_ALU) && (q_op == OP_DIV);

  // Operands come straight from the bank so the divider starts on the
  // acceptance edge, giving exactly REG_WIDTH cycles in DIV.
  seq_div #(
    .WIDTH(W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (accept && in_is_div),
    .dividend_i (rs1_val),
    .divisor_i  (rs2_val),
    .done_o     (div_done),
    .dz_o       (div_dz),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = in_is_div ? ST_DIV : ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_DIV:  if (div_done) state_d = ST_WB;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    wide      = '0;
    prod      = '0;
    if (q_mode[1]) begin
      alu_flags[FLAG_ILL] = 1'b1;
    end else if (q_mode == MODE_LDI) begin
      alu_res = {{(W-LW){1'b0}}, instr_q[LW-1:0]};
    end else begin
      case (q_op)
        OP_ADD: begin
          wide                = {1'b0, opa_q} + {1'b0, opb_q};
          alu_res             = wide[W-1:0];
          alu_flags[FLAG_CO]  = wide[W];
          alu_flags[FLAG_OVF] = (opa_q[W-1] == opb_q[W-1]) && (wide[W-1] != opa_q[W-1]);
        end
        OP_SUB: begin
          wide                = {1'b0, opa_q} - {1'b0, opb_q};
          alu_res             = wide[W-1:0];
          alu_flags[FLAG_CO]  = wide[W];
          alu_flags[FLAG_OVF] = (opa_q[W-1] != opb_q[W-1]) && (wide[W-1] != opa_q[W-1]);
        end
        OP_MUL: begin
          prod               = {{W{1'b0}}, opa_q} * {{W{1'b0}}, opb_q};
          alu_res            = prod[W-1:0];
          alu_flags[FLAG_CO] = |prod[2*W-1:W];
        end
        default: ;
      endcase
    end
  end

  assign wr_en    = (state_q == ST_WB) && !q_mode[1];
  assign wr_data  = q_is_div ? div_quo : result_q;
  assign wb_flags = q_is_div ? {1'b0, div_dz, 2'b00} : eflags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      eflags_q <= '0;
      flags_q  <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept) begin
        instr_q <= instr;
        opa_q   <= rs1_val;
        opb_q   <= rs2_val;
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_res;
        eflags_q <= alu_flags;
      end
      if (state_q == ST_WB) begin
        done_q  <= 1'b1;
        flags_q <= wb_flags;
        if (q_is_div) rem_q <= div_rem;
      end
    end
  end

  // Single write port; reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[instr_q[RD_LSB +: RIDX]] <= wr_data;
    end
  end

  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);
  assign flags    = flags_q;
  assign rem_out  = rem_q;
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: doc/cpu_exec_core.md
CPU_EXEC_CORE -- requirements
Module: cpu_exec_core

Interface
REQ-001 Parameter NUM_REG, default 16: register bank depth; SHALL be a power of two from 4 to 16.
REQ-002 Parameter REG_WIDTH, default 16: width of each register and of the datapath; SHALL be even and at least 8.
REQ-003 Derived constant RIDX = clog2(NUM_REG); the instruction width SHALL be 4+3*RIDX, which is 16 at the defaults.
REQ-004 clk  in  1  Single clock; all state SHALL update on the rising edge only.
REQ-005 rst  in  1  Synchronous, active-high reset.
REQ-006 instr_valid  in  1  Instruction offered.
REQ-007 instr_ready  out  1  Core able to accept an instruction.
REQ-008 instr  in  4+3*RIDX  Fields, MSB first: mode[2], op[2], rd[RIDX], rs1[RIDX], rs2[RIDX].
REQ-009 done  out  1  One-cycle pulse when an instruction retires.
REQ-010 busy  out  1  High whenever the state is not IDLE.
REQ-011 flags  out  4  Per-instruction flags {ill, dz, ovf, co}, registered and held until the next retire.
REQ-012 rem_out  out  REG_WIDTH  Remainder of the last DIV, held until the next DIV retires.
REQ-013 dbg_sel  in  RIDX  Debug register select.
REQ-014 dbg_data  out  REG_WIDTH  Combinational read of reg_bank[dbg_sel].

Function
REQ-015 The FSM SHALL have four states: IDLE, EXEC, DIV and WB.
REQ-016 instr_ready SHALL equal (state == IDLE); an instruction is accepted on an edge where instr_valid and instr_ready are both 1.
REQ-017 On acceptance the core SHALL latch the instruction and the rs1/rs2 register values; later register writes SHALL NOT affect these latched operands.
REQ-018 An accepted instruction SHALL move the FSM from IDLE to DIV when mode=00 and op=11; every other accepted instruction SHALL move it to EXEC.
REQ-019 EXEC SHALL last one cycle, compute the result into a result register, then go to WB.
REQ-020 DIV SHALL perform unsigned restoring division, one quotient bit per cycle, for exactly REG_WIDTH cycles, then go to WB.
REQ-021 In WB the core SHALL write rd (unless ill=1), update flags, assert done for that cycle, and return to IDLE.
REQ-022 Latency from the acceptance edge to rd being visible on dbg_data SHALL be 3 edges for non-DIV instructions and REG_WIDTH+2 edges for DIV.
REQ-023 mode=00, op=00 (ADD): rd = rs1+rs2 modulo 2^REG_WIDTH; co = carry out; ovf = signed overflow.
REQ-024 mode=00, op=01 (SUB): rd = rs1-rs2 modulo 2^REG_WIDTH; co = borrow (rs1<rs2); ovf = signed overflow.
REQ-025 mode=00, op=10 (MUL): unsigned multiply; rd = low REG_WIDTH bits of the product; co = 1 if the high half is non-zero; ovf = 0.
REQ-026 mode=00, op=11 (DIV): rd = quotient; rem_out = remainder.
REQ-027 DIV with rs2 = 0: rd = all-ones, rem_out = rs1, dz = 1; the full DIV duration SHALL still elapse.
REQ-028 mode=01 (LDI): rd = zero-extended {rs1,rs2} field (2*RIDX bits); all flags = 0.
REQ-029 mode=1x: illegal instruction; no register write; ill = 1; all other flags = 0; it SHALL still take the EXEC and WB path and pulse done.
REQ-030 rd equal to rs1 or rs2 is legal; the result SHALL be computed from the operands latched at acceptance.
REQ-031 instr_valid while busy SHALL be ignored; the offered instruction is not consumed.
REQ-032 flags and rem_out SHALL change only in WB.

Reset
REQ-033 With rst=1 on an edge: state = IDLE, every reg_bank entry = 0, flags = 0, rem_out = 0, done = 0, and the division counter, quotient and remainder registers = 0.
REQ-034 Reset during EXEC, DIV or WB SHALL abort the instruction with no register write and no done pulse; instr_ready SHALL be 1 in the cycle after the reset edge.
REQ-035 An instruction offered in the same cycle as rst=1 SHALL NOT be accepted.

Structure
REQ-036 Package cpu_pkg SHALL hold the op and mode enums, the state enum, the flag bit indices and the instruction field offsets as functions of RIDX.
REQ-037 The iterative divider SHALL be a sub-module, seq_div, with start/done handshake and dz output, parametrised by REG_WIDTH.
REQ-038 The register bank SHALL be a single flop array with one write port and three read ports (rs1, rs2, dbg).

Verification (NUM_REG=16, REG_WIDTH=16)
REQ-039 After reset: LDI r1=0xFF, then LDI r2=0x01, then ADD r3=r1+r2 -> r3=0x0100, co=0, ovf=0; done pulses 3 times, each 3 edges after its acceptance.
REQ-040 Preload r1=0x7FFF and r2=0x0001 via LDI/ADD chains, then ADD r4=r1+r2 -> r4=0x8000, ovf=1, co=0; SUB r5=r2-r1 -> r5=0x8002, co=1.
REQ-041 MUL with r1=0x0100 and r2=0x0100 -> rd=0x0000, co=1.
REQ-042 DIV 0x00FF/0x0010 -> rd=0x000F, rem_out=0x000F, done exactly 18 edges after acceptance; DIV by r0=0 -> rd=0xFFFF, rem_out=dividend, dz=1.
REQ-043 Hold instr_valid high during DIV -> instr_ready=0 throughout and only one instruction is consumed; mode=10 -> ill=1, no register change, done pulses.
REQ-044 Assert rst mid-DIV -> no done pulse, all registers 0, instr_ready=1 in the next cycle.
